// File: rtl/sub_4bit_serial.sv
// sub_4bit_serial: bit-serial two's-complement subtractor, DIFF = A - B - BIn, LSB first.
// Ports: clk/reset, start/busy/done handshake, A/B/BIn operands, DIFF/Overflow/Borrow/Zero results.
module sub_4bit_serial #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             BIn,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] DIFF,
  output logic             Overflow,
  output logic             Borrow,
  output logic             Zero
);

  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             br_q, br_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             sa_q, sa_d;
  logic             sb_q, sb_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             ovf_q, ovf_d;
  logic             bout_q, bout_d;
  logic             zero_q, zero_d;

  logic             bit_d;
  logic             br_nx;
  logic [WIDTH-1:0] res_sh;

  always_comb begin
    bit_d  = a_q[0] ^ b_q[0] ^ br_q;
    br_nx  = (~a_q[0] & b_q[0]) |
             (~(a_q[0] ^ b_q[0]) & br_q);
    res_sh = {bit_d, res_q[WIDTH-1:1]};
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    br_d    = br_q;
    cnt_d   = cnt_q;
    sa_d    = sa_q;
    sb_d    = sb_q;
    diff_d  = diff_q;
    ovf_d   = ovf_q;
    bout_d  = bout_q;
    zero_d  = zero_q;

    unique case (state_q)
      IDLE, DONE: begin
        if (state_q == DONE) state_d = IDLE;
        if (start) begin
          state_d = SHIFT;
          a_d     = A;
          b_d     = B;
          br_d    = BIn;
          res_d   = '0;
          cnt_d   = '0;
          // sign bits survive the shifting for overflow
          sa_d    = A[WIDTH-1];
          sb_d    = B[WIDTH-1];
        end
      end
      SHIFT: begin
        a_d   = a_q >> 1;
        b_d   = b_q >> 1;
        br_d  = br_nx;
        res_d = res_sh;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(WIDTH - 1)) begin
          state_d = DONE;
          diff_d  = res_sh;
          bout_d  = br_nx;
          zero_d  = (res_sh == '0);
          ovf_d   = (sa_q != sb_q) &&
                    (res_sh[WIDTH-1] != sa_q);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      br_q    <= 1'b0;
      cnt_q   <= '0;
      sa_q    <= 1'b0;
      sb_q    <= 1'b0;
      diff_q  <= '0;
      ovf_q   <= 1'b0;
      bout_q  <= 1'b0;
      zero_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      br_q    <= br_d;
      cnt_q   <= cnt_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
      diff_q  <= diff_d;
      ovf_q   <= ovf_d;
      bout_q  <= bout_d;
      zero_q  <= zero_d;
    end
  end

  assign busy     = (state_q == SHIFT);
  assign done     = (state_q == DONE);
  assign DIFF     = diff_q;
  assign Overflow = ovf_q;
  assign Borrow   = bout_q;
  assign Zero     = zero_q;

endmodule

// File: tb/tb_sub_4bit_serial.sv
// tb_sub_4bit_serial: directed and random checks of the serial subtractor.
// Expected values come from an integer-arithmetic reference model.
module tb_sub_4bit_serial;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [3:0] A;
  logic [3:0] B;
  logic       BIn;
  logic       busy;
  logic       done;
  logic [3:0] DIFF;
  logic       Overflow;
  logic       Borrow;
  logic       Zero;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  sub_4bit_serial #(.WIDTH(4)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .A        (A),
    .B        (B),
    .BIn      (BIn),
    .busy     (busy),
    .done     (done),
    .DIFF     (DIFF),
    .Overflow (Overflow),
    .Borrow   (Borrow),
    .Zero     (Zero)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  task automatic model(input  logic [3:0] a,
                       input  logic [3:0] b,
                       input  logic       bin,
                       output logic [3:0] d,
                       output logic       o,
                       output logic       bw,
                       output logic       z);
    int s;
    int u;
    s  = int'($signed(a)) - int'($signed(b)) - int'(bin);
    u  = int'(a) - int'(b) - int'(bin);
    d  = 4'(u);
    bw = (u < 0);
    o  = (s < -8) || (s > 7);
    z  = (d == 4'd0);
  endtask

  task automatic wait_done(output int n);
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (!done && n < 20);
  endtask

  task automatic check_model(input string tag,
                             input logic [3:0] a,
                             input logic [3:0] b,
                             input logic bin);
    logic [3:0] ed;
    logic eo, eb, ez;
    model(a, b, bin, ed, eo, eb, ez);
    chk({tag, "_diff"}, DIFF, ed);
    chk({tag, "_ovf"}, Overflow, eo);
    chk({tag, "_brw"}, Borrow, eb);
    chk({tag, "_zero"}, Zero, ez);
  endtask

  task automatic run_op(input logic [3:0] a,
                        input logic [3:0] b,
                        input logic bin,
                        input string tag);
    int n;
    A = a;
    B = b;
    BIn = bin;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    chk({tag, "_busy"}, busy, 1);
    A = 4'($urandom);
    B = 4'($urandom);
    BIn = 1'($urandom);
    wait_done(n);
    chk({tag, "_lat"}, n, 4);
    check_model(tag, a, b, bin);
    @(posedge clk);
    #1;
    chk({tag, "_dclr"}, done, 0);
  endtask

  initial begin : main
    int nd;
    int n;
    logic [3:0] dv;
    logic [3:0] bc;

    reset = 1'b1;
    start = 1'b0;
    A = 4'd0;
    B = 4'd0;
    BIn = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_out", {DIFF, Overflow, Borrow, Zero}, 0);
    reset = 1'b0;

    run_op(4'b1000, 4'b0001, 1'b0, "t1");
    chk("t1_const", {DIFF, Overflow, Borrow, Zero}, 7'b0111_100);
    run_op(4'b0011, 4'b0101, 1'b0, "t2");
    chk("t2_const", {DIFF, Overflow, Borrow, Zero}, 7'b1110_010);
    run_op(4'b0111, 4'b1111, 1'b0, "t3");
    chk("t3_const", {DIFF, Overflow, Borrow, Zero}, 7'b1000_110);
    run_op(4'b0101, 4'b0101, 1'b0, "t4");
    chk("t4_const", {DIFF, Overflow, Borrow, Zero}, 7'b0000_001);
    run_op(4'b0000, 4'b0000, 1'b1, "t5");
    chk("t5_const", {DIFF, Overflow, Borrow, Zero}, 7'b1111_010);

    repeat (6) @(posedge clk);
    #1;
    chk("hold", {DIFF, Overflow, Borrow, Zero}, 7'b1111_010);

    // second start during SHIFT must be dropped
    A = 4'b1000;
    B = 4'b0001;
    BIn = 1'b0;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    @(posedge clk);
    #1;
    A = 4'b1111;
    B = 4'b1111;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    nd = 0;
    dv = 4'd0;
    repeat (8) begin
      @(posedge clk);
      #1;
      if (done) begin
        nd++;
        dv = DIFF;
      end
    end
    chk("ign_ndone", nd, 1);
    chk("ign_diff", dv, 4'b0111);

    // reset mid-operation abandons it
    A = 4'b1000;
    B = 4'b0001;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    chk("abort_busy", busy, 0);
    nd = 0;
    repeat (8) begin
      @(posedge clk);
      #1;
      if (done) nd++;
    end
    chk("abort_ndone", nd, 0);
    chk("abort_out", {DIFF, Overflow, Borrow, Zero}, 0);
    run_op(4'b0110, 4'b0010, 1'b0, "t6");
    chk("t6_const", {DIFF, Overflow, Borrow, Zero}, 7'b0100_000);

    // back-to-back issue with start held high
    A = 4'b1000;
    B = 4'b0001;
    BIn = 1'b0;
    start = 1'b1;
    @(posedge clk);
    #1;
    for (int i = 0; i < 5; i++) begin
      bc = 4'(i + 1);
      wait_done(n);
      chk("b2b_period", n, (i == 0) ? 4 : 5);
      check_model("b2b", 4'b1000, bc, 1'b0);
      chk("b2b_const", DIFF, 4'(8 - (i + 1)));
      chk("b2b_busy", busy, 0);
      if (i < 4) B = 4'(i + 2);
      else start = 1'b0;
    end
    @(posedge clk);
    #1;
    chk("b2b_end", {busy, done}, 0);

    repeat (24) begin
      run_op(4'($urandom), 4'($urandom), 1'($urandom), "rnd");
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
